mem_access_fsm: RTL
===================

MEM_ACCESS_FSM -- requirements
Module: mem_access_fsm

Interface
REQ-001 The block SHALL have a parameter DATA_W, default 32, giving the width of the register data, address, offset and memory data.
REQ-002 The block SHALL have a parameter SEL_W, default 3, giving the register-select width.
REQ-003 The block SHALL have a parameter TIMEOUT, default 16, giving the maximum number of MEM_REQ cycles to wait for mem_ack; 0 disables the timeout.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port r, input, 1, the reset; it is synchronous and active-high.
REQ-006 The block SHALL have port start, input, 1, which requests an operation; it is sampled only in IDLE.
REQ-007 The block SHALL have port op, input, 1: 0 = array index, a <- (b)[c]; 1 = array amend, (a)[b] <- c.
REQ-008 The block SHALL have ports regA, regB and regC, input, SEL_W each, the operand register numbers; they are captured on start.
REQ-009 The block SHALL have port reg_out_bus, input, DATA_W, the combinational register-file read data for reg_sel.
REQ-010 The block SHALL have ports reg_sel (output, SEL_W), reg_we (output, 1) and reg_wdata (output, DATA_W), the register-file port.
REQ-011 The block SHALL have ports mem_req (output, 1), mem_we (output, 1), mem_addr (output, DATA_W), mem_off (output, DATA_W) and mem_wdata (output, DATA_W), the memory request.
REQ-012 The block SHALL have ports mem_ack (input, 1) and mem_rdata (input, DATA_W), the memory completion and read data.
REQ-013 The block SHALL have ports busy (output, 1), finished (output, 1, single-cycle pulse) and err (output, 1, single-cycle pulse with finished on timeout).

Function
REQ-014 The states SHALL be IDLE, RD_ADDR, RD_OFF, RD_DATA, MEM_REQ, WB and DONE.
REQ-015 IDLE with start=1 SHALL capture op and regA/B/C and go to RD_ADDR; start=0 SHALL hold IDLE.
REQ-016 reg_sel SHALL be combinational from state: RD_ADDR selects regB (op 0) or regA (op 1); RD_OFF selects regC (op 0) or regB (op 1); RD_DATA selects regC; WB selects regA; otherwise it is 0.
REQ-017 Each read state SHALL capture reg_out_bus at its closing edge: RD_ADDR into addr, RD_OFF into off, RD_DATA into wdata.
REQ-018 Transitions SHALL be: RD_ADDR to RD_OFF; RD_OFF to MEM_REQ (op 0) or to RD_DATA (op 1); RD_DATA to MEM_REQ.
REQ-019 In MEM_REQ, mem_req SHALL be 1 and mem_we SHALL equal op, with mem_addr, mem_off and mem_wdata driven from the captured registers and held stable until ack.
REQ-020 In MEM_REQ with mem_ack=1, the block SHALL capture mem_rdata and go to WB (op 0) or DONE (op 1); an ack in the same cycle as the timeout limit wins over the timeout.
REQ-021 In WB, reg_we SHALL be 1 and reg_wdata SHALL be the captured mem_rdata, for exactly one cycle; WB then goes to DONE.
REQ-022 A wait counter SHALL count MEM_REQ cycles; when TIMEOUT>0 and the count reaches TIMEOUT with no ack, the block SHALL go to DONE with err set and perform no WB.
REQ-023 DONE SHALL assert finished=1, plus err if a timeout occurred, for one cycle, then return to IDLE; a start during DONE SHALL be ignored.
REQ-024 busy SHALL be 1 in every state except IDLE; start in any non-IDLE state SHALL be ignored.
REQ-025 Latency with ack in the first MEM_REQ cycle SHALL be finished 5 cycles after the start-sampling edge, for both op values.
REQ-026 reg_we and mem_req SHALL never be 1 in the same cycle.

Reset
REQ-027 When r=1 at a clock edge, the state SHALL become IDLE and busy, finished, err, mem_req, mem_we and reg_we SHALL be 0; the captured registers and the counter SHALL be cleared to 0.
REQ-028 A reset during any state, including MEM_REQ, SHALL abort the operation with no WB and no finished pulse; a later mem_ack SHALL be ignored in IDLE.

Structure
REQ-029 The state enum and the op encoding (OP_IDX, OP_AMEND) SHALL live in the shared package BusTypes.
REQ-030 The wait counter SHALL be one sub-module, wait_timer, with clear, enable and limit inputs and an expired output.

Verification
REQ-031 Index test: r2=0x100, r3=0x4, op=0 a=1 b=2 c=3, ack in the first MEM_REQ cycle with rdata=0xDEADBEEF -> r1=0xDEADBEEF written in WB, finished at cycle 5.
REQ-032 Amend test: r1=0x200, r2=0x8, r3=0x55, op=1 -> mem_req with we=1, addr=0x200, off=0x8, wdata=0x55; ack after 3 wait cycles -> finished at cycle 8 and no reg_we.
REQ-033 Timeout test: TIMEOUT=4 and ack held low -> 4 MEM_REQ cycles, then finished and err pulse together, with reg_we never 1.
REQ-034 Reset test: r asserted in the second MEM_REQ cycle, then ack given -> IDLE with all outputs 0 and no writeback.
REQ-035 Back-to-back test: start held high continuously -> one operation per 6 cycles, with start ignored while busy.
REQ-036 Width test: DATA_W=16 and SEL_W=4 with reg 15 as the destination and rdata=0xFFFF -> r15=0xFFFF.

Source files
------------

// File: rtl/BusTypes.sv
// Shared types for the memory-access sequencer: FSM state encoding, operation
// encoding and the wait-counter width.
package BusTypes;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_OFF,
    RD_DATA,
    MEM_REQ,
    WB,
    DONE
  } state_t;

  // OP_IDX: a <- (b)[c]; OP_AMEND: (a)[b] <- c
  typedef enum logic {
    OP_IDX   = 1'b0,
    OP_AMEND = 1'b1
  } op_t;

  localparam int TMR_W = 16;

endpackage

// File: rtl/wait_timer.sv
// Counts enabled cycles and flags the cycle in which the count reaches the limit.
// A limit of zero never expires.
module wait_timer
  import BusTypes::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         r,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (r) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // Count starts at 0 in the first enabled cycle, so limit-1 marks the limit-th cycle.
  assign expired = enable && (limit != '0) && (count >= limit - 1'b1);

endmodule

// File: rtl/mem_access_fsm.sv
// Sequencer for array index/amend: reads operand registers, issues one memory
// request with optional timeout, and writes the loaded word back for index ops.
module mem_access_fsm
  import BusTypes::*;
#(
  parameter int DATA_W  = 32,
  parameter int SEL_W   = 3,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              r,
  input  logic              start,
  input  logic              op,
  input  logic [SEL_W-1:0]  regA,
  input  logic [SEL_W-1:0]  regB,
  input  logic [SEL_W-1:0]  regC,
  input  logic [DATA_W-1:0] reg_out_bus,
  output logic [SEL_W-1:0]  reg_sel,
  output logic              reg_we,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_off,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              finished,
  output logic              err
);

  state_t            state, next;
  op_t               op_q;
  logic [SEL_W-1:0]  a_q, b_q, c_q;
  logic [DATA_W-1:0] addr_q, off_q, wdata_q, rdata_q;
  logic              timed_out_q;
  logic              tmr_clr, tmr_en, tmr_expired;

  wait_timer #(.W(TMR_W)) u_wait_timer (
    .clk     (clk),
    .r       (r),
    .clear   (tmr_clr),
    .enable  (tmr_en),
    .limit   (TMR_W'(TIMEOUT)),
    .expired (tmr_expired)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (r) state <= IDLE;
    else   state <= next;
  end

  always_ff @(posedge clk) begin
    if (r) begin
      op_q        <= OP_IDX;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      addr_q      <= '0;
      off_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      timed_out_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q        <= op_t'(op);
          a_q         <= regA;
          b_q         <= regB;
          c_q         <= regC;
          timed_out_q <= 1'b0;
        end
        RD_ADDR: addr_q  <= reg_out_bus;
        RD_OFF:  off_q   <= reg_out_bus;
        RD_DATA: wdata_q <= reg_out_bus;
        MEM_REQ: begin
          if (mem_ack)          rdata_q     <= mem_rdata;
          else if (tmr_expired) timed_out_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    next      = state;
    reg_sel   = '0;
    reg_we    = 1'b0;
    reg_wdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_off   = '0;
    mem_wdata = '0;
    busy      = (state != IDLE);
    finished  = 1'b0;
    err       = 1'b0;
    tmr_en    = 1'b0;
    tmr_clr   = 1'b1;
    case (state)
      IDLE:    if (start) next = RD_ADDR;
      RD_ADDR: begin
        reg_sel = (op_q == OP_IDX) ? b_q : a_q;
        next    = RD_OFF;
      end
      RD_OFF: begin
        reg_sel = (op_q == OP_IDX) ? c_q : b_q;
        next    = (op_q == OP_IDX) ? MEM_REQ : RD_DATA;
      end
      RD_DATA: begin
        reg_sel = c_q;
        next    = MEM_REQ;
      end
      MEM_REQ: begin
        mem_req   = 1'b1;
        mem_we    = (op_q == OP_AMEND);
        mem_addr  = addr_q;
        mem_off   = off_q;
        mem_wdata = (op_q == OP_AMEND) ? wdata_q : '0;
        tmr_en    = 1'b1;
        tmr_clr   = 1'b0;
        // An ack landing on the limit cycle still completes the access.
        if (mem_ack)          next = (op_q == OP_IDX) ? WB : DONE;
        else if (tmr_expired) next = DONE;
      end
      WB: begin
        reg_sel   = a_q;
        reg_we    = 1'b1;
        reg_wdata = rdata_q;
        next      = DONE;
      end
      DONE: begin
        finished = 1'b1;
        err      = timed_out_q;
        next     = IDLE;
      end
      default: next = IDLE;
    endcase
  end

endmodule
